// File: rtl/centering_unit.sv
// centering_unit: captures one frame of multichannel samples, then replays it with the per-channel mean removed
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   GO              frame start, honoured only in IDLE
//   IN_valid/_data  input samples, channel k at [k*DATA_W +: DATA_W]; IN_ready high while loading
//   OUT_valid/_data centered samples, channel k at [k*(DATA_W+1) +: DATA_W+1]; OUT_last on the final one
//   CEN_busy        LOAD through DRAIN; CEN_done one-cycle end-of-frame pulse
module centering_unit #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16,
  parameter int N_SAMP = 128,
  parameter int LOG2_N = 7
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         GO,
  input  logic                         IN_valid,
  input  logic [N_CH*DATA_W-1:0]       IN_data,
  output logic                         IN_ready,
  output logic                         OUT_valid,
  output logic [N_CH*(DATA_W+1)-1:0]   OUT_data,
  output logic                         OUT_last,
  output logic                         CEN_busy,
  output logic                         CEN_done
);
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int OUT_W = DATA_W + 1;
  localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N_SAMP - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MEAN, S_EMIT, S_DRAIN, S_DONE} state_t;
  state_t                   state_q;
  logic [LOG2_N-1:0]        cnt_q;
  logic [N_CH*DATA_W-1:0]   mem_q [N_SAMP];
  logic [N_CH*DATA_W-1:0]   rd;
  logic signed [ACC_W-1:0]  acc_q [N_CH];
  logic signed [ACC_W-1:0]  acc_d [N_CH];
  logic signed [DATA_W-1:0] mean_q [N_CH];
  logic signed [DATA_W-1:0] mean_d [N_CH];
  logic [N_CH*OUT_W-1:0]    out_d;
  assign IN_ready = (state_q == S_LOAD);
  // Mean is the accumulator's top DATA_W bits: an arithmetic shift by LOG2_N (floor) then truncation.
  always_comb begin
    rd = mem_q[cnt_q];
    for (int k = 0; k < N_CH; k++) begin
      acc_d[k]  = acc_q[k] + ACC_W'($signed(IN_data[k*DATA_W +: DATA_W]));
      mean_d[k] = acc_q[k][LOG2_N +: DATA_W];
      out_d[k*OUT_W +: OUT_W] = OUT_W'($signed(rd[k*DATA_W +: DATA_W])) - OUT_W'(mean_q[k]);
    end
  end
  always_ff @(posedge CLK)
    if (state_q == S_LOAD && IN_valid) mem_q[cnt_q] <= IN_data;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      OUT_valid <= 1'b0;
      OUT_data  <= '0;
      OUT_last  <= 1'b0;
      CEN_busy  <= 1'b0;
      CEN_done  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k]  <= '0;
        mean_q[k] <= '0;
      end
    end else begin
      OUT_valid <= 1'b0;
      OUT_data  <= '0;
      OUT_last  <= 1'b0;
      CEN_done  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
          if (GO) begin
            state_q  <= S_LOAD;
            CEN_busy <= 1'b1;
          end
        end
        S_LOAD: if (IN_valid) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_MEAN;
        end
        S_MEAN: begin
          mean_q  <= mean_d;
          state_q <= S_EMIT;
        end
        // Buffer is read combinationally, so the address issued here lands in the output register next cycle.
        S_EMIT: begin
          OUT_valid <= 1'b1;
          OUT_data  <= out_d;
          OUT_last  <= (cnt_q == LAST);
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          CEN_done <= 1'b1;
          CEN_busy <= 1'b0;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_centering_unit.sv
// tb_centering_unit: randomized self-checking bench for centering_unit against a floor-mean reference model
module tb_centering_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        GO = 1'b0;
  logic        IN_valid = 1'b0;
  logic [31:0] IN_data = '0;
  logic        IN_ready, OUT_valid, OUT_last, CEN_busy, CEN_done;
  logic [33:0] OUT_data;
  int checks = 0, failures = 0, cyc = 0;
  int s0[128], s1[128], e0[128], e1[128];
  int o0[$], o1[$];
  int n_acc, t_acc, first_out, last_cyc, n_last, done_cyc, n_done, gaps, nz_inv;
  bit rdy_after, go_ok, prev_valid;
  centering_unit dut (
    .CLK(CLK), .RST(RST), .GO(GO), .IN_valid(IN_valid), .IN_data(IN_data),
    .IN_ready(IN_ready), .OUT_valid(OUT_valid), .OUT_data(OUT_data), .OUT_last(OUT_last),
    .CEN_busy(CEN_busy), .CEN_done(CEN_done)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask
  function automatic int floor_mean(input int sum);
    int m;
    m = sum / 128;
    if (sum < 0 && m * 128 != sum) m--;
    return m;
  endfunction
  task automatic build_exp();
    int a, b;
    a = 0;
    b = 0;
    for (int i = 0; i < 128; i++) begin
      a += s0[i];
      b += s1[i];
    end
    a = floor_mean(a);
    b = floor_mean(b);
    for (int i = 0; i < 128; i++) begin
      e0[i] = s0[i] - a;
      e1[i] = s1[i] - b;
    end
  endtask
  // Drives one frame (GO, samples, optional gaps/spurious traffic) and records what the DUT produced.
  task automatic run_frame(input int gap, input bit spur, input bit go_emit);
    int idx, c;
    bit v;
    idx = 0; n_acc = 0; t_acc = -1; first_out = -1; last_cyc = -1; n_last = 0;
    done_cyc = -1; n_done = 0; gaps = 0; nz_inv = 0; rdy_after = 1'b1; prev_valid = 1'b0;
    o0.delete();
    o1.delete();
    GO = 1'b1;
    tick();
    GO = 1'b0;
    go_ok = IN_ready && CEN_busy;
    c = 0;
    while (n_done == 0 && c < 3000) begin
      if (OUT_valid) begin
        o0.push_back($signed(OUT_data[16:0]));
        o1.push_back($signed(OUT_data[33:17]));
        if (first_out < 0) first_out = cyc;
        else if (!prev_valid) gaps++;
      end else if (OUT_data !== '0) nz_inv++;
      prev_valid = OUT_valid;
      if (OUT_last) begin n_last++; last_cyc = cyc; end
      if (CEN_done) begin n_done++; done_cyc = cyc; end
      if (t_acc >= 0 && cyc == t_acc + 1) rdy_after = IN_ready;
      if (idx < 128) begin
        v = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        IN_valid = v;
        IN_data = v ? {s1[idx][15:0], s0[idx][15:0]} : $urandom;
      end else begin
        IN_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        IN_data = $urandom;
      end
      GO = go_emit && t_acc >= 0 && cyc == t_acc + 10;
      if (IN_valid && IN_ready) begin
        n_acc++;
        if (idx < 128) begin
          idx++;
          if (idx == 128) t_acc = cyc;
        end
      end
      tick();
      c++;
    end
    IN_valid = 1'b0;
    GO = 1'b0;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    IN_valid = 1'b1;
    IN_data = $urandom;
    tick();
    tick();
    checks++; if (IN_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", IN_ready); end
    checks++; if (OUT_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", OUT_valid); end
    checks++; if (OUT_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", OUT_data); end
    checks++; if (OUT_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", OUT_last); end
    checks++; if (CEN_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", CEN_busy); end
    checks++; if (CEN_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", CEN_done); end
    RST = 1'b0;
    tick();
    tick();
    checks++; if (IN_ready !== 1'b0 || CEN_busy !== 1'b0) begin failures++; $display("FAIL idle_no_go got=%b%b exp=00", IN_ready, CEN_busy); end
    IN_valid = 1'b0;
  endtask
  task automatic test_constant();
    for (int i = 0; i < 128; i++) begin s0[i] = 100; s1[i] = -7; end
    build_exp();
    run_frame(0, 1'b0, 1'b0);
    checks++; if (!go_ok) begin failures++; $display("FAIL const_go got=0 exp=1"); end
    checks++; if (n_acc !== 128) begin failures++; $display("FAIL const_accepts got=%0d exp=128", n_acc); end
    checks++; if (o0.size() !== 128) begin failures++; $display("FAIL const_count got=%0d exp=128", o0.size()); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== 0 || o1[i] !== 0 || o0[i] !== e0[i]) begin
        failures++; $display("FAIL const_data[%0d] got=%0d,%0d exp=0,0", i, o0[i], o1[i]);
      end
    end
    checks++; if (first_out !== t_acc + 3) begin failures++; $display("FAIL const_first_out got=%0d exp=%0d", first_out, t_acc + 3); end
    checks++; if (n_last !== 1 || last_cyc !== t_acc + 130) begin failures++; $display("FAIL const_last got=%0d@%0d exp=1@%0d", n_last, last_cyc, t_acc + 130); end
    checks++; if (n_done !== 1 || done_cyc !== t_acc + 131) begin failures++; $display("FAIL const_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, t_acc + 131); end
    checks++; if (gaps !== 0 || nz_inv !== 0) begin failures++; $display("FAIL const_burst gaps=%0d nonzero_idle=%0d exp=0,0", gaps, nz_inv); end
    checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL const_ready_after got=%b exp=0", rdy_after); end
  endtask
  task automatic test_ramp();
    for (int i = 0; i < 128; i++) begin s0[i] = i; s1[i] = -1; end
    build_exp();
    run_frame(0, 1'b0, 1'b0);
    checks++; if (o0.size() !== 128) begin failures++; $display("FAIL ramp_count got=%0d exp=128", o0.size()); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== e0[i] || o1[i] !== e1[i]) begin
        failures++; $display("FAIL ramp_data[%0d] got=%0d,%0d exp=%0d,%0d", i, o0[i], o1[i], e0[i], e1[i]);
      end
    end
    checks++; if (o0.size() == 128 && (o0[0] !== -63 || o0[127] !== 64)) begin failures++; $display("FAIL ramp_ends got=%0d,%0d exp=-63,64", o0[0], o0[127]); end
  endtask
  task automatic test_extreme();
    for (int i = 0; i < 128; i++) begin s0[i] = (i == 127) ? -32768 : 32767; s1[i] = -32768; end
    build_exp();
    run_frame(0, 1'b0, 1'b0);
    checks++; if (o0.size() !== 128) begin failures++; $display("FAIL extreme_count got=%0d exp=128", o0.size()); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== e0[i] || o1[i] !== e1[i]) begin
        failures++; $display("FAIL extreme_data[%0d] got=%0d,%0d exp=%0d,%0d", i, o0[i], o1[i], e0[i], e1[i]);
      end
    end
    checks++; if (o0.size() == 128 && (o0[0] !== 512 || o0[127] !== -65023 || o1[5] !== 0)) begin failures++; $display("FAIL extreme_ends got=%0d,%0d,%0d exp=512,-65023,0", o0[0], o0[127], o1[5]); end
  endtask
  task automatic test_gapped();
    for (int i = 0; i < 128; i++) begin s0[i] = i; s1[i] = -1; end
    build_exp();
    run_frame(1, 1'b1, 1'b0);
    checks++; if (n_acc !== 128) begin failures++; $display("FAIL gap_accepts got=%0d exp=128", n_acc); end
    checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL gap_ready_after got=%b exp=0", rdy_after); end
    checks++; if (o0.size() !== 128 || gaps !== 0) begin failures++; $display("FAIL gap_burst got=%0d gaps=%0d exp=128 gaps=0", o0.size(), gaps); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== e0[i] || o1[i] !== e1[i]) begin
        failures++; $display("FAIL gap_data[%0d] got=%0d,%0d exp=%0d,%0d", i, o0[i], o1[i], e0[i], e1[i]);
      end
    end
  endtask
  task automatic test_go_busy_and_abort();
    for (int i = 0; i < 128; i++) begin s0[i] = $urandom_range(0, 65535) - 32768; s1[i] = $urandom_range(0, 65535) - 32768; end
    build_exp();
    run_frame(0, 1'b1, 1'b1);
    checks++; if (o0.size() !== 128 || n_done !== 1) begin failures++; $display("FAIL gobusy_burst got=%0d done=%0d exp=128 done=1", o0.size(), n_done); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== e0[i] || o1[i] !== e1[i]) begin
        failures++; $display("FAIL gobusy_data[%0d] got=%0d,%0d exp=%0d,%0d", i, o0[i], o1[i], e0[i], e1[i]);
      end
    end
    tick();
    tick();
    checks++; if (CEN_busy !== 1'b0 || IN_ready !== 1'b0) begin failures++; $display("FAIL gobusy_idle got=%b%b exp=00", CEN_busy, IN_ready); end
    GO = 1'b1;
    tick();
    GO = 1'b0;
    IN_valid = 1'b1;
    for (int i = 0; i < 59; i++) begin IN_data = $urandom; tick(); end
    IN_data = $urandom;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    IN_valid = 1'b0;
    checks++;
    if (IN_ready !== 1'b0 || OUT_valid !== 1'b0 || OUT_data !== '0 || OUT_last !== 1'b0 || CEN_busy !== 1'b0 || CEN_done !== 1'b0) begin
      failures++; $display("FAIL abort_outputs got=%b%b%h%b%b%b exp=all zero", IN_ready, OUT_valid, OUT_data, OUT_last, CEN_busy, CEN_done);
    end
    tick();
    tick();
    checks++; if (CEN_busy !== 1'b0 || IN_ready !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b%b exp=00", CEN_busy, IN_ready); end
    for (int i = 0; i < 128; i++) begin s0[i] = 50; s1[i] = 50; end
    build_exp();
    run_frame(0, 1'b0, 1'b0);
    checks++; if (o0.size() !== 128) begin failures++; $display("FAIL abort_count got=%0d exp=128", o0.size()); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== 0 || o1[i] !== 0) begin
        failures++; $display("FAIL abort_data[%0d] got=%0d,%0d exp=0,0", i, o0[i], o1[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 128; i++) begin s0[i] = $urandom_range(0, 65535) - 32768; s1[i] = $urandom_range(0, 2000) - 1000; end
    build_exp();
    run_frame(2, 1'b0, 1'b0);
    checks++; if (o0.size() !== 128 || n_done !== 1) begin failures++; $display("FAIL b2b_first got=%0d done=%0d exp=128 done=1", o0.size(), n_done); end
    for (int i = 0; i < 128; i++) begin s0[i] = 10; s1[i] = $urandom_range(0, 65535) - 32768; end
    build_exp();
    run_frame(0, 1'b0, 1'b0);
    checks++; if (!go_ok) begin failures++; $display("FAIL b2b_go got=0 exp=1"); end
    checks++; if (o0.size() !== 128) begin failures++; $display("FAIL b2b_count got=%0d exp=128", o0.size()); end
    for (int i = 0; i < o0.size() && i < 128; i++) begin
      checks++;
      if (o0[i] !== 0 || o1[i] !== e1[i]) begin
        failures++; $display("FAIL b2b_data[%0d] got=%0d,%0d exp=0,%0d", i, o0[i], o1[i], e1[i]);
      end
    end
  endtask
  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 128; i++) begin s0[i] = $urandom_range(0, 65535) - 32768; s1[i] = $urandom_range(0, 65535) - 32768; end
      build_exp();
      run_frame(2, 1'b1, 1'b0);
      checks++; if (o0.size() !== 128 || n_acc !== 128) begin failures++; $display("FAIL rand_count got=%0d acc=%0d exp=128", o0.size(), n_acc); end
      for (int i = 0; i < o0.size() && i < 128; i++) begin
        checks++;
        if (o0[i] !== e0[i] || o1[i] !== e1[i]) begin
          failures++; $display("FAIL rand_data[%0d] got=%0d,%0d exp=%0d,%0d", i, o0[i], o1[i], e0[i], e1[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_extreme();
    test_gapped();
    test_go_busy_and_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
